// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencing FSM: IF/ID/EX/MEM/WB control plus retired counter.
// Optional macro HALT_ON_ECALL_EN: ECALL with ecall_halt_req enters absorbing HALT.
module multicycle_control_fsm #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             bcond,
   input  logic             ecall_halt_req,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_source,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic [1:0]       mem_to_reg,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op_signal,
   output logic             is_halted,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_SYS  = 7'b1110011;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   // bcond qualifies the PC write in the datapath; the FSM never needs it
   logic unused_ok;
   assign unused_ok = ^{bcond, ecall_halt_req};

   // state and retired counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // an instruction retires on the edge that leaves it for IF or HALT
   always_comb begin
      retire = (state_q != S_IF) && (state_q != S_HALT) &&
               ((state_d == S_IF) || (state_d == S_HALT));
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, retire};
   end

   assign retired_cnt = cnt_q;

   // next-state and Moore control decode
   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op_signal = 2'b00;
      is_halted     = 1'b0;
      unique case (state_q)
         S_IF: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
            state_d   = S_ID;
         end
         S_ID: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            state_d   = S_EX;
         end
         S_EX: begin
            state_d = S_IF;
            unique case (opcode)
               OP_R: begin
                  alu_src_a     = 2'b01;
                  alu_op_signal = 2'b10;
                  state_d       = S_WB;
               end
               OP_I: begin
                  alu_src_a     = 2'b01;
                  alu_src_b     = 2'b10;
                  alu_op_signal = 2'b10;
                  state_d       = S_WB;
               end
               OP_LD, OP_ST: begin
                  alu_src_a     = 2'b01;
                  alu_src_b     = 2'b10;
                  alu_op_signal = 2'b10;
                  state_d       = S_MEM;
               end
               OP_BR: begin
                  alu_src_a     = 2'b01;
                  alu_op_signal = 2'b01;
                  pc_write_cond = 1'b1;
                  pc_source     = 1'b1;
               end
               OP_JAL: begin
                  pc_write   = 1'b1;
                  pc_source  = 1'b1;
                  reg_write  = 1'b1;
                  mem_to_reg = 2'b10;
               end
               OP_JALR: begin
                  alu_src_a     = 2'b01;
                  alu_src_b     = 2'b10;
                  alu_op_signal = 2'b10;
                  pc_write      = 1'b1;
                  reg_write     = 1'b1;
                  mem_to_reg    = 2'b10;
               end
`ifdef HALT_ON_ECALL_EN
               OP_SYS: begin
                  if (ecall_halt_req) state_d = S_HALT;
               end
`endif
               default: ;
            endcase
         end
         S_MEM: begin
            i_or_d = 1'b1;
            if (opcode == OP_LD) begin
               mem_read = 1'b1;
               state_d  = S_WB;
            end else begin
               mem_write = (opcode == OP_ST);
               state_d   = S_IF;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (opcode == OP_LD) ? 2'b01 : 2'b00;
            state_d    = S_IF;
         end
         S_HALT: begin
`ifdef HALT_ON_ECALL_EN
            is_halted = 1'b1;
            state_d   = S_HALT;
`else
            state_d   = S_IF;
`endif
         end
         default: state_d = S_IF;
      endcase
   end

endmodule
